lii_pkt_scheduler: RTL and testbench
====================================

// Module: lii_pkt_scheduler
// PURPOSE
//  Packet-atomic output scheduler for one LII router output port. Picks one of N_IN input queues, holds the
//  grant from the first beat to the LAST beat so packets never interleave, and serves two traffic classes
//  (hi/lo) with per-class round-robin and lo-class anti-starvation. Also drops stuck locks on timeout.
//  One instance sits per output in front of the crossbar mux; gnt selects the mux input.
// PARAMETERS
//  N_IN          4   number of requesters (input queues); >=2
//  STARVE_MAX    4   hi-packet completions tolerated while lo waits before lo is forced; 0 = disabled
//  LOCK_TIMEOUT  256 cycles in LOCKED with no accepted beat before lock abort; 0 = disabled
//  CNT_W         9   width of timeout counter; must hold LOCK_TIMEOUT
// PORTS
//  clk          in   1          clock; all state on rising edge
//  rst          in   1          synchronous reset, active-high
//  req          in   N_IN       head-beat valid of each input queue
//  hi           in   N_IN       head-beat class of each queue (1 = hi); sampled only at packet start
//  last         in   N_IN       head-beat LAST flag of each queue
//  out_ready    in   1          downstream ready of this output port
//  gnt          out  N_IN       one-hot selected requester (drives crossbar mux and queue ready)
//  gnt_v        out  1          out_valid: selected requester has a beat (= |(gnt & req))
//  gnt_idx      out  $clog2(N_IN) binary index of gnt
//  locked       out  1          1 while mid-packet (state LOCKED)
//  starve_boost out  1          1 while lo class is being forced ahead of hi
//  err_timeout  out  1          one-cycle pulse when a lock is aborted by timeout
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=IDLE, ptr_hi=ptr_lo=0, starve_cnt=0, to_cnt=0. Outputs combinational
//    from state: after reset gnt/gnt_v/locked/starve_boost/err_timeout all 0 until req goes high.
//  - accept = gnt_v & out_ready (one beat transferred). Grant is zero-latency (combinational on req).
//  - IDLE: candidate set = lo reqs if starve_boost and any lo req, else hi reqs if any, else lo reqs.
//    Pick first set bit at or after class pointer, wrapping N_IN-1 -> 0. gnt_v=1 iff candidate set non-empty.
//    accept & !last[sel] -> LOCKED, latch owner=sel and class=hi[sel]. accept & last[sel] -> stay IDLE,
//    packet complete (single beat). No accept -> choice may change next cycle (no lock yet).
//  - LOCKED: gnt=onehot(owner) regardless of other reqs; gnt_v=req[owner]. Owner dropping req keeps the
//    lock (gnt_v=0, no other requester granted). accept & last[owner] -> IDLE, packet complete.
//  - Packet complete: pointer of owner's class <= (owner+1) mod N_IN; other class pointer unchanged.
//  - Starvation: on hi completion while any lo req pending, starve_cnt++ (saturating at STARVE_MAX).
//    starve_boost = (STARVE_MAX!=0) & (starve_cnt==STARVE_MAX). Lo completion or no lo req pending in
//    IDLE clears starve_cnt.
//  - Timeout: in LOCKED, to_cnt++ each cycle without accept; cleared on accept and on entering LOCKED.
//    When to_cnt reaches LOCK_TIMEOUT-1 with no accept: err_timeout=1 that cycle, next state IDLE,
//    class pointer advances as on completion (abort; downstream packet is truncated, flagged by err only).
//    Accept in the same cycle wins: no abort. LOCK_TIMEOUT=0: never aborts.
//  - Reset mid-packet drops the lock immediately; the partial packet is not resumed.
//  - gnt is always one-hot or zero; never more than one bit set.
// TESTING (N_IN=4, STARVE_MAX=2, LOCK_TIMEOUT=8 unless noted; out_ready=1)
//  1 Lock: req=0011, all lo, q0 sends 3 beats last on 3rd, q1 single beats -> gnt=0001 x3, then 0010.
//  2 RR: req=1111 lo, all single-beat -> gnt_idx sequence 0,1,2,3,0; ptr_lo wraps 3->0.
//  3 Starve: req0 lo, req1 hi, continuous single-beat -> gnt_idx 1,1,0,1,1,0; starve_boost high on 0 grants.
//  4 Hold: locked to q2, req[2]=0 for 3 cycles while req0=1 -> gnt=0100, gnt_v=0, q0 never granted.
//  5 Timeout: locked to q1, req[1]=0 forever, req3=1 -> err_timeout pulse on 8th idle cycle, gnt=1000 next.
//  6 Reset mid-packet: locked to q3 after 2 beats, rst=1 one cycle -> locked=0, next grant from ptr 0.

Source files
------------

// File: rtl/lii_pkt_scheduler.sv
// lii_pkt_scheduler
//   Packet-atomic output scheduler for one LII router output port. Selects one
//   of N_IN input queues and holds the grant from the first beat to the LAST
//   beat. Two traffic classes (hi/lo), each with its own round-robin pointer.
//   The lo class is forced ahead of hi after STARVE_MAX hi completions while lo
//   waits. A lock is aborted if LOCK_TIMEOUT cycles pass with no accepted beat.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   req          head-beat valid per input queue
//   hi           head-beat class per queue (1 = hi), used at packet start
//   last         head-beat LAST flag per queue
//   out_ready    downstream ready of this output port
//   gnt          one-hot selected requester (crossbar mux select / queue ready)
//   gnt_v        selected requester has a beat (out_valid)
//   gnt_idx      binary index of gnt (0 when gnt is zero)
//   locked       high while mid-packet
//   starve_boost high while lo class is forced ahead of hi
//   err_timeout  one-cycle pulse when a lock is aborted by timeout
module lii_pkt_scheduler #(
  parameter int N_IN         = 4,
  parameter int STARVE_MAX   = 4,
  parameter int LOCK_TIMEOUT = 256,
  parameter int CNT_W        = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN-1:0]         req,
  input  logic [N_IN-1:0]         hi,
  input  logic [N_IN-1:0]         last,
  input  logic                    out_ready,
  output logic [N_IN-1:0]         gnt,
  output logic                    gnt_v,
  output logic [$clog2(N_IN)-1:0] gnt_idx,
  output logic                    locked,
  output logic                    starve_boost,
  output logic                    err_timeout
);

  localparam int IDX_W = $clog2(N_IN);
  localparam int SC_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr_hi, ptr_lo;
  logic [IDX_W-1:0] owner;
  logic             owner_hi;
  logic [SC_W-1:0]  starve_cnt;
  logic [CNT_W-1:0] to_cnt;

  logic [N_IN-1:0]  hi_req, lo_req, cand;
  logic             cand_hi, use_lo, lo_pending;
  logic [IDX_W-1:0] base, sel;
  logic             sel_found;

  logic             accept;
  logic             start;      // first beat of a multi-beat packet accepted in IDLE
  logic             complete;   // LAST beat accepted
  logic             advance;    // completion or abort: move the class pointer
  logic [IDX_W-1:0] done_idx;
  logic             done_hi;

  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N_IN - 1)) return '0;
    else                       return i + 1'b1;
  endfunction

  assign hi_req       = req & hi;
  assign lo_req       = req & ~hi;
  assign lo_pending   = |lo_req;
  assign starve_boost = (STARVE_MAX != 0) && (starve_cnt == SC_W'(STARVE_MAX));
  assign use_lo       = starve_boost && lo_pending;
  assign cand_hi      = !use_lo && (|hi_req);
  assign cand         = cand_hi ? hi_req : lo_req;
  assign base         = cand_hi ? ptr_hi : ptr_lo;
  assign locked       = (state == LOCKED);

  // First candidate at or after the class pointer, wrapping N_IN-1 -> 0.
  always_comb begin
    int unsigned idx;
    sel       = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      idx = 32'(base) + i;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!sel_found && cand[IDX_W'(idx)]) begin
        sel       = IDX_W'(idx);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt         = '0;
    gnt_v       = 1'b0;
    gnt_idx     = '0;
    accept      = 1'b0;
    start       = 1'b0;
    complete    = 1'b0;
    advance     = 1'b0;
    done_idx    = '0;
    done_hi     = 1'b0;
    err_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          gnt[sel] = 1'b1;
          gnt_v    = 1'b1;
          gnt_idx  = sel;
        end
        accept = gnt_v & out_ready;
        if (accept) begin
          if (last[sel]) begin
            complete = 1'b1;
            advance  = 1'b1;
            done_idx = sel;
            done_hi  = hi[sel];
          end else begin
            start     = 1'b1;
            state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        gnt[owner] = 1'b1;
        gnt_v      = req[owner];
        gnt_idx    = owner;
        accept     = gnt_v & out_ready;
        done_idx   = owner;
        done_hi    = owner_hi;
        if (accept) begin
          if (last[owner]) begin
            complete  = 1'b1;
            advance   = 1'b1;
            state_nxt = IDLE;
          end
        end else if (LOCK_TIMEOUT != 0 && to_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          err_timeout = 1'b1;
          advance     = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr_hi     <= '0;
      ptr_lo     <= '0;
      owner      <= '0;
      owner_hi   <= 1'b0;
      starve_cnt <= '0;
      to_cnt     <= '0;
    end else begin
      state <= state_nxt;

      if (start) begin
        owner    <= sel;
        owner_hi <= hi[sel];
      end

      if (state == LOCKED && !accept && state_nxt == LOCKED)
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;

      if (advance) begin
        if (done_hi) ptr_hi <= inc_idx(done_idx);
        else         ptr_lo <= inc_idx(done_idx);
      end

      // Aborts move the pointer but are not completions for starvation counting.
      if (complete && done_hi && lo_pending) begin
        if (starve_cnt != SC_W'(STARVE_MAX))
          starve_cnt <= starve_cnt + 1'b1;
      end else if (complete && !done_hi) begin
        starve_cnt <= '0;
      end else if (state == IDLE && !lo_pending) begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lii_pkt_scheduler.sv
// tb_lii_pkt_scheduler
//   Directed bench for lii_pkt_scheduler with N_IN=4, STARVE_MAX=2,
//   LOCK_TIMEOUT=8, CNT_W=4.
module tb_lii_pkt_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, hi, last;
  logic       out_ready;
  logic [3:0] gnt;
  logic       gnt_v;
  logic [1:0] gnt_idx;
  logic       locked, starve_boost, err_timeout;

  int total = 0;
  int bad   = 0;

  int seq_rr[5]     = '{0, 1, 2, 3, 0};
  int seq_idx[6]    = '{1, 1, 0, 1, 1, 0};
  int seq_boost[6]  = '{0, 0, 1, 0, 0, 1};

  lii_pkt_scheduler #(
    .N_IN        (4),
    .STARVE_MAX  (2),
    .LOCK_TIMEOUT(8),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .hi          (hi),
    .last        (last),
    .out_ready   (out_ready),
    .gnt         (gnt),
    .gnt_v       (gnt_v),
    .gnt_idx     (gnt_idx),
    .locked      (locked),
    .starve_boost(starve_boost),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; hi = '0; last = '0; out_ready = 1'b1;
    do_reset();
    #1;
    chk("rst_gnt",    32'(gnt), 32'h0);
    chk("rst_gnt_v",  32'(gnt_v), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_boost",  32'(starve_boost), 32'h0);
    chk("rst_err",    32'(err_timeout), 32'h0);

    // 1: lock on q0 for a 3-beat packet, q1 single beats
    req = 4'b0011; hi = 4'b0000; last = 4'b0010;
    #1;
    chk("t1_b1_gnt",    32'(gnt), 32'h1);
    chk("t1_b1_locked", 32'(locked), 32'h0);
    tick();
    chk("t1_b2_gnt",    32'(gnt), 32'h1);
    chk("t1_b2_locked", 32'(locked), 32'h1);
    tick();
    last = 4'b0011;
    #1;
    chk("t1_b3_gnt",    32'(gnt), 32'h1);
    tick();
    chk("t1_q1_gnt",    32'(gnt), 32'h2);
    chk("t1_q1_locked", 32'(locked), 32'h0);
    tick();
    chk("t1_wrap_gnt",  32'(gnt), 32'h1);
    req = '0;

    // 2: lo round-robin, all single-beat
    do_reset();
    req = 4'b1111; hi = 4'b0000; last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t2_idx%0d", k), 32'(gnt_idx), 32'(seq_rr[k]));
      tick();
    end
    req = '0;

    // 3: starvation boost, q0 lo vs q1 hi
    do_reset();
    req = 4'b0011; hi = 4'b0010; last = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t3_idx%0d", k),   32'(gnt_idx), 32'(seq_idx[k]));
      chk($sformatf("t3_boost%0d", k), 32'(starve_boost), 32'(seq_boost[k]));
      tick();
    end
    req = '0;

    // 4: no lock without out_ready, then owner drops req while locked
    do_reset();
    req = 4'b0100; hi = 4'b0000; last = 4'b0000; out_ready = 1'b0;
    #1;
    chk("t4_nordy_gnt_v", 32'(gnt_v), 32'h1);
    tick();
    chk("t4_nordy_locked", 32'(locked), 32'h0);
    out_ready = 1'b1;
    tick();
    req = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t4_hold_gnt%0d", k),   32'(gnt), 32'h4);
      chk($sformatf("t4_hold_gntv%0d", k),  32'(gnt_v), 32'h0);
      chk($sformatf("t4_hold_lock%0d", k),  32'(locked), 32'h1);
      tick();
    end
    req = 4'b0101; last = 4'b0100;
    #1;
    chk("t4_last_gnt_v", 32'(gnt_v), 32'h1);
    tick();
    chk("t4_after_locked", 32'(locked), 32'h0);
    chk("t4_after_idx",    32'(gnt_idx), 32'h0);
    req = '0;

    // 5: lock timeout on q1, q3 waiting
    do_reset();
    req = 4'b0010; hi = 4'b0000; last = 4'b0000;
    tick();
    req = 4'b1000;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("t5_err%0d", k), 32'(err_timeout), 32'((k == 8) ? 1 : 0));
      chk($sformatf("t5_gnt%0d", k), 32'(gnt), 32'h2);
      tick();
    end
    chk("t5_post_locked", 32'(locked), 32'h0);
    chk("t5_post_gnt",    32'(gnt), 32'h8);
    chk("t5_post_err",    32'(err_timeout), 32'h0);
    req = '0;

    // 6: reset mid-packet (ptr_lo is 2 here, so q3 is picked)
    req = 4'b1000; hi = 4'b0000; last = 4'b0000;
    #1;
    chk("t6_b1_gnt", 32'(gnt), 32'h8);
    tick();
    chk("t6_b2_locked", 32'(locked), 32'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1010;
    #1;
    chk("t6_rst_locked", 32'(locked), 32'h0);
    chk("t6_rst_idx",    32'(gnt_idx), 32'h1);
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
